prog_loader: RTL and testbench

Byte-serial program loader on the input side of the pipelined RISC-V CPU, complementing the 16-bit result path that the CPU drives out. Takes program bytes from the dedicated input pins using a 4-phase strobe/ack handshake and assembles them little-endian into 32-bit instruction words. Writes each word into sequential instruction-memory addresses. Holds the CPU in reset while loading and releases it when the host drops the load request.

---
 rtl/prog_loader.sv | 148 ++++++++++++++
 tb/tb_prog_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-serial program loader: 4-phase strobe/ack host link, little-endian word
// assembly into sequential instruction-memory writes, CPU held in reset while loading.
module prog_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              stb,
  input  logic [7:0]        din,
  output logic              ack,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic [1:0]        state,
  output logic              ovf
);

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    LOAD  = 2'b01,
    WRITE = 2'b10,
    RUN   = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic                req_meta_q, req_meta_d;
  logic                load_req_s_q, load_req_s_d;
  logic                stb_meta_q, stb_meta_d;
  logic                stb_s_q, stb_s_d;
  logic                stb_d_q, stb_d_d;
  logic                pend_q, pend_d;
  logic [1:0]          idx_q, idx_d;
  logic                ack_q, ack_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic                stb_rise;
  logic                consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HOLD;
      req_meta_q   <= 1'b0;
      load_req_s_q <= 1'b0;
      stb_meta_q   <= 1'b0;
      stb_s_q      <= 1'b0;
      stb_d_q      <= 1'b0;
      pend_q       <= 1'b0;
      idx_q        <= '0;
      ack_q        <= 1'b0;
      full_q       <= 1'b0;
      ovf_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rst_n_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_meta_q   <= req_meta_d;
      load_req_s_q <= load_req_s_d;
      stb_meta_q   <= stb_meta_d;
      stb_s_q      <= stb_s_d;
      stb_d_q      <= stb_d_d;
      pend_q       <= pend_d;
      idx_q        <= idx_d;
      ack_q        <= ack_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD:    state_d = load_req_s_q ? LOAD : RUN;
      LOAD: begin
        if (!load_req_s_q)                                  state_d = RUN;
        else if (pend_q && (idx_q == 2'd3) && !full_q)      state_d = WRITE;
      end
      WRITE:   state_d = LOAD;
      RUN:     if (load_req_s_q) state_d = LOAD;
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    req_meta_d   = load_req;
    load_req_s_d = req_meta_q;
    stb_meta_d   = stb;
    stb_s_d      = stb_meta_q;
    stb_d_d      = stb_s_q;
    stb_rise     = stb_s_q & ~stb_d_q;
    // A load-request drop wins over a pending byte, so nothing is consumed then.
    consume      = (state_q == LOAD) && load_req_s_q && pend_q;
    pend_d       = (pend_q & ~consume) | stb_rise;
    ack_d        = consume ? 1'b1 : (stb_s_q ? ack_q : 1'b0);
    idx_d        = idx_q;
    full_d       = full_q;
    ovf_d        = ovf_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      HOLD, RUN: begin
        pend_d = 1'b0;
        if (state_d == LOAD) begin
          addr_d = '0;
          idx_d  = '0;
          ovf_d  = 1'b0;
          full_d = 1'b0;
        end
      end
      LOAD: begin
        if (!load_req_s_q) begin
          idx_d  = '0;
          pend_d = 1'b0;
        end else if (pend_q) begin
          if (full_q) ovf_d = 1'b1;
          else        wdata_d[{idx_q, 3'b000} +: 8] = din;
          idx_d = idx_q + 2'd1;
        end
      end
      WRITE: begin
        // The last address is held rather than wrapped; full blocks further writes.
        if (addr_q == '1) full_d = 1'b1;
        else              addr_d = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase
    cpu_rst_n_d = (state_d == RUN);
  end

  always_comb begin
    state      = state_q;
    imem_we    = (state_q == WRITE);
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
    ack        = ack_q;
    cpu_rst_n  = cpu_rst_n_q;
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default-size and a 4-word instance share the host
// stimulus; expected memory writes are queued per instance and checked as they appear.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        load_req;
  logic        stb;
  logic [7:0]  din;

  logic        ack_b, we_b, crst_b, ovf_b;
  logic [5:0]  addr_b;
  logic [31:0] wdata_b;
  logic [1:0]  st_b;
  logic        ack_s, we_s, crst_s, ovf_s;
  logic [1:0]  addr_s;
  logic [31:0] wdata_s;
  logic [1:0]  st_s;

  int unsigned n_vec;
  int unsigned n_err;
  logic [37:0] q_big[$];
  logic [37:0] q_small[$];

  prog_loader u_dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .stb(stb), .din(din),
    .ack(ack_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .cpu_rst_n(crst_b), .state(st_b), .ovf(ovf_b)
  );

  prog_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .stb(stb), .din(din),
    .ack(ack_s), .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s),
    .cpu_rst_n(crst_s), .state(st_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [37:0] e;
    if (we_b === 1'b1) begin
      if (q_big.size() == 0) chk("we_big_unexpected", 32'(we_b), 32'd0);
      else begin
        e = q_big.pop_front();
        chk("addr_big", 32'(addr_b), 32'(e[37:32]));
        chk("data_big", wdata_b, e[31:0]);
      end
    end
    if (we_s === 1'b1) begin
      if (q_small.size() == 0) chk("we_small_unexpected", 32'(we_s), 32'd0);
      else begin
        e = q_small.pop_front();
        chk("addr_small", 32'(addr_s), 32'(e[37:32]));
        chk("data_small", wdata_s, e[31:0]);
      end
    end
  end

  task automatic push_both(input int unsigned a, input logic [31:0] d);
    q_big.push_back({6'(a), d});
    q_small.push_back({6'(a), d});
  endtask

  task automatic wait_ack(input logic v, input int unsigned max);
    int unsigned n = 0;
    while (!(ack_b === v && ack_s === v) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("ack_wait", {30'd0, ack_b, ack_s}, {30'd0, v, v});
  endtask

  task automatic wait_state(input logic [1:0] s, input int unsigned max);
    int unsigned n = 0;
    while (!(st_b === s && st_s === s) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("state_wait", {28'd0, st_b, st_s}, {28'd0, s, s});
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ack(1'b0, 20);
    din = b;
    stb = 1'b1;
    wait_ack(1'b1, 20);
    stb = 1'b0;
    wait_ack(1'b0, 20);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {28'd0, st_b, st_s}, 32'd0);
    chk({tag, "_cpu_rst_n"}, {30'd0, crst_b, crst_s}, 32'd0);
    chk({tag, "_we"}, {30'd0, we_b, we_s}, 32'd0);
    chk({tag, "_addr"}, {24'd0, addr_b, addr_s}, 32'd0);
    chk({tag, "_wdata_b"}, wdata_b, 32'd0);
    chk({tag, "_wdata_s"}, wdata_s, 32'd0);
    chk({tag, "_ack"}, {30'd0, ack_b, ack_s}, 32'd0);
    chk({tag, "_ovf"}, {30'd0, ovf_b, ovf_s}, 32'd0);
  endtask

  initial begin
    logic [7:0] b20 [20];
    logic [31:0] w;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    load_req = 1'b0;
    stb = 1'b0;
    din = 8'h00;

    // Reset values, then free-run into RUN.
    @(negedge clk);
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("run_state", {28'd0, st_b, st_s}, 32'hF);
    chk("run_cpu_rst_n", {30'd0, crst_b, crst_s}, 32'd3);
    stb = 1'b1;
    din = 8'h5A;
    repeat (8) @(negedge clk);
    chk("run_no_ack", {30'd0, ack_b, ack_s}, 32'd0);
    stb = 1'b0;
    repeat (4) @(negedge clk);

    // Two-word load.
    load_req = 1'b1;
    wait_state(2'b01, 6);
    chk("load_cpu_rst_n", {30'd0, crst_b, crst_s}, 32'd0);
    chk("load_addr0", {24'd0, addr_b, addr_s}, 32'd0);
    push_both(0, 32'h0000_0013);
    push_both(1, 32'h0000_12B7);
    send_word(32'h0000_0013);
    send_word(32'h0000_12B7);
    chk("two_word_addr", {24'd0, addr_b, addr_s}, {24'd0, 6'd2, 2'd2});
    load_req = 1'b0;
    wait_state(2'b11, 6);
    chk("drop_cpu_rst_n", {30'd0, crst_b, crst_s}, 32'd3);
    chk("drop_addr", {24'd0, addr_b, addr_s}, {24'd0, 6'd2, 2'd2});

    // Partial word discarded on drop; reload restarts at address 0, byte 0.
    load_req = 1'b1;
    wait_state(2'b01, 6);
    chk("reload_addr", {24'd0, addr_b, addr_s}, 32'd0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    load_req = 1'b0;
    wait_state(2'b11, 6);
    chk("partial_addr", {24'd0, addr_b, addr_s}, 32'd0);
    load_req = 1'b1;
    wait_state(2'b01, 6);
    push_both(0, 32'h0403_0201);
    send_word(32'h0403_0201);
    chk("after_partial_addr", {24'd0, addr_b, addr_s}, {24'd0, 6'd1, 2'd1});

    // A strobe rise landing in the WRITE cycle must be captured once, next LOAD.
    push_both(1, 32'h1413_1211);
    push_both(2, 32'h1817_1615);
    send_byte(8'h11);
    send_byte(8'h12);
    send_byte(8'h13);
    repeat (3) @(negedge clk);
    din = 8'h14;
    stb = 1'b1;                       // sampled at edge N
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
    stb = 1'b1;                       // sampled at N+2, rise seen at N+4
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);                   // after N+3: 4th byte captured, WRITE
    chk("pend_write_state", {28'd0, st_b, st_s}, 32'hA);
    din = 8'h15;
    @(negedge clk);                   // after N+4: back in LOAD, byte pending
    chk("pend_load_state", {28'd0, st_b, st_s}, 32'h5);
    @(negedge clk);                   // after N+5: pending byte captured
    chk("pend_ack", {30'd0, ack_b, ack_s}, 32'd3);
    send_byte(8'h16);
    send_byte(8'h17);
    send_byte(8'h18);
    chk("pend_addr", {24'd0, addr_b, addr_s}, {24'd0, 6'd3, 2'd3});

    // Fill the 4-word instance: 20 bytes, 4 writes, overflow on the 17th byte.
    load_req = 1'b0;
    wait_state(2'b11, 6);
    load_req = 1'b1;
    wait_state(2'b01, 6);
    for (int i = 0; i < 20; i++) b20[i] = 8'(8'h40 + i);
    for (int k = 0; k < 5; k++) begin
      w = {b20[4*k+3], b20[4*k+2], b20[4*k+1], b20[4*k]};
      q_big.push_back({6'(k), w});
      if (k < 4) q_small.push_back({6'(k), w});
    end
    for (int i = 0; i < 20; i++) begin
      send_byte(b20[i]);
      if (i == 15) chk("ovf_after_16", 32'(ovf_s), 32'd0);
      if (i == 16) chk("ovf_after_17", 32'(ovf_s), 32'd1);
    end
    chk("full_addr_small", 32'(addr_s), 32'd3);
    chk("full_addr_big", 32'(addr_b), 32'd5);
    chk("ovf_big", 32'(ovf_b), 32'd0);
    chk("ovf_small_sticky", 32'(ovf_s), 32'd1);

    // Asynchronous reset mid-word.
    send_byte(8'hE1);
    send_byte(8'hE2);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_state(2'b01, 10);
    chk("post_reset_addr", {24'd0, addr_b, addr_s}, 32'd0);
    push_both(0, 32'hDDCC_BBAA);
    send_word(32'hDDCC_BBAA);
    chk("post_reset_addr1", {24'd0, addr_b, addr_s}, {24'd0, 6'd1, 2'd1});
    load_req = 1'b0;
    wait_state(2'b11, 6);
    repeat (5) @(negedge clk);
    chk("q_big_drained", q_big.size(), 32'd0);
    chk("q_small_drained", q_small.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
